// File: rtl/fb_tx_pkg.sv
// Shared constants and state encoding for the transceiver-side byte arbiter.
// Control characters follow the 8b/10b K-code values used on the link.
package fb_tx_pkg;

    localparam logic [7:0] IDLE_CHAR           = 8'hBC;
    localparam logic [7:0] DATA_TRANSFER_START = 8'h5C;
    localparam logic [7:0] DATA_TRANSFER_STOP  = 8'h3C;

    typedef logic [1:0] fb_tx_state_t;

    localparam fb_tx_state_t ST_IDLE = 2'd0;
    localparam fb_tx_state_t ST_SEND = 2'd1;
    localparam fb_tx_state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/rr_prio_select_m.sv
// Combinational winner select: source 0 has fixed top priority, sources
// 1..N-1 are searched round-robin starting at ptr (ptr is always in 1..N-1).
module rr_prio_select_m #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        if (req[0]) begin
            valid = 1'b1;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                idx = int'(ptr) + k;
                // wrap inside 1..N-1, skipping the priority source
                if (idx >= N) idx = idx - (N - 1);
                if (!valid && req[idx[IW-1:0]]) begin
                    valid  = 1'b1;
                    winner = idx[IW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/fb_tx_arbiter.sv
// Packet arbiter feeding one transceiver byte lane from SRC_COUNT sources.
// Optional stall watchdog enabled by defining FB_TX_ARB_WDT_EN.
//
// state   | meaning
// IDLE    | no owner; sends IDLE_CHAR, picks a winner on a tx_ena slot
// SEND    | owner's bytes pass through; IDLE_CHAR while the owner stalls
// GAP     | one IDLE_CHAR slot after a packet before the next grant
module fb_tx_arbiter #(
    parameter int         SRC_COUNT = 4,
    parameter logic [7:0] IDLE_CHAR = fb_tx_pkg::IDLE_CHAR,
    parameter int         WDT_SLOTS = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tx_ena,
    input  logic [SRC_COUNT-1:0]         src_req,
    input  logic [SRC_COUNT-1:0][7:0]    src_data,
    input  logic [SRC_COUNT-1:0]         src_isk,
    input  logic [SRC_COUNT-1:0]         src_last,
    output logic [SRC_COUNT-1:0]         src_ack,
    output logic [7:0]                   tx_data_out,
    output logic                         tx_isk_out,
    output logic [$clog2(SRC_COUNT)-1:0] grant_id,
    output logic                         busy,
    output logic                         abort
);

    import fb_tx_pkg::*;

    localparam int IW = $clog2(SRC_COUNT);

    fb_tx_state_t  state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel_winner;
    logic          sel_valid;
    logic          owner_req;
    logic          owner_last;
    logic          stall_abort;

    rr_prio_select_m #(.N(SRC_COUNT)) u_select (
        .req    (src_req),
        .ptr    (rr_ptr),
        .winner (sel_winner),
        .valid  (sel_valid)
    );

    assign owner_req  = src_req[grant_id];
    assign owner_last = src_last[grant_id];
    assign busy       = (state != ST_IDLE);

`ifdef FB_TX_ARB_WDT_EN
    localparam int WW = $clog2(WDT_SLOTS + 1);

    logic [WW-1:0] wdt_cnt;

    // fires on the WDT_SLOTS-th consecutive stalled slot
    assign stall_abort = (state == ST_SEND) && tx_ena && !owner_req &&
                         (wdt_cnt == WW'(WDT_SLOTS - 1));
    assign abort       = stall_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (state != ST_SEND) begin
            wdt_cnt <= '0;
        end else if (tx_ena) begin
            if (owner_req || stall_abort) wdt_cnt <= '0;
            else                          wdt_cnt <= wdt_cnt + WW'(1);
        end
    end
`else
    assign stall_abort = 1'b0;
    assign abort       = 1'b0;
`endif

    always_comb begin
        src_ack     = '0;
        tx_data_out = 8'h00;
        tx_isk_out  = 1'b0;
        if (tx_ena) begin
            case (state)
                ST_SEND: begin
                    if (owner_req) begin
                        tx_data_out       = src_data[grant_id];
                        tx_isk_out        = src_isk[grant_id];
                        src_ack[grant_id] = 1'b1;
                    end else if (stall_abort) begin
                        tx_data_out = DATA_TRANSFER_STOP;
                        tx_isk_out  = 1'b1;
                    end else begin
                        tx_data_out = IDLE_CHAR;
                        tx_isk_out  = 1'b1;
                    end
                end
                default: begin
                    tx_data_out = IDLE_CHAR;
                    tx_isk_out  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            rr_ptr   <= IW'(1);
        end else if (tx_ena) begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state    <= ST_SEND;
                        grant_id <= sel_winner;
                        // source 0 wins outside the rotation, so it leaves the pointer alone
                        if (sel_winner != '0) begin
                            rr_ptr <= (sel_winner == IW'(SRC_COUNT - 1)) ? IW'(1)
                                                                          : sel_winner + IW'(1);
                        end
                    end
                end
                ST_SEND: begin
                    if ((owner_req && owner_last) || stall_abort) state <= ST_GAP;
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_tx_arbiter.sv
// Self-checking bench for fb_tx_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_fb_tx_arbiter;

    localparam int         N    = 4;
    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         WDT  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                tx_ena;
    logic [N-1:0]        src_req;
    logic [N-1:0][7:0]   src_data;
    logic [N-1:0]        src_isk;
    logic [N-1:0]        src_last;
    logic [N-1:0]        src_ack;
    logic [7:0]          tx_data_out;
    logic                tx_isk_out;
    logic [1:0]          grant_id;
    logic                busy;
    logic                abort;

    always #5 clk = ~clk;

    fb_tx_arbiter #(.SRC_COUNT(N), .IDLE_CHAR(IDLE), .WDT_SLOTS(WDT)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_ena      (tx_ena),
        .src_req     (src_req),
        .src_data    (src_data),
        .src_isk     (src_isk),
        .src_last    (src_last),
        .src_ack     (src_ack),
        .tx_data_out (tx_data_out),
        .tx_isk_out  (tx_isk_out),
        .grant_id    (grant_id),
        .busy        (busy),
        .abort       (abort)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       isk;
        logic       last;
    } byte_t;

    byte_t src_q [N][$];
    int    stall_left [N];

    int n_cmp = 0;
    int n_bad = 0;

    // model: who owns the lane, whether the gap slot is pending, rotation pointer
    bit         m_sending, m_gap;
    int         m_owner, m_ptr, m_wdt;
    logic [1:0] m_grant;

    logic [8:0] slot_log [$];
    int         grant_log [$];
    int         ack_cnt [N];
    int         abort_cnt;
    bit         prev_busy;
    logic [8:0] exp_slots [$];
    int         exp_grants [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req);
        int c;
        if (req[0]) return 0;
        for (int k = 0; k < N - 1; k++) begin
            c = m_ptr + k;
            if (c >= N) c -= N - 1;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic add_byte(input int s, input logic [7:0] d, input logic k, input logic l);
        byte_t b;
        b.data = d; b.isk = k; b.last = l;
        src_q[s].push_back(b);
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            if (src_q[s].size() > 0) begin
                src_req[s]  = (stall_left[s] == 0);
                src_data[s] = src_q[s][0].data;
                src_isk[s]  = src_q[s][0].isk;
                src_last[s] = src_q[s][0].last;
            end else begin
                src_req[s]  = 1'b0;
                src_data[s] = 8'($urandom);
                src_isk[s]  = 1'($urandom_range(0, 1));
                src_last[s] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic clear_logs();
        slot_log.delete();
        grant_log.delete();
        for (int s = 0; s < N; s++) ack_cnt[s] = 0;
        abort_cnt = 0;
    endtask

    task automatic step(input bit ena);
        byte_t      b;
        logic [N-1:0] e_ack;
        logic [7:0] e_data;
        logic       e_isk, e_abort;
        int         w;
        @(negedge clk);
        rst    = 1'b0;
        tx_ena = ena;
        drive();
        #1;
        check("busy", 32'(busy), 32'(m_sending || m_gap));
        if (m_sending || m_gap) check("grant_id", 32'(grant_id), 32'(m_grant));
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        e_ack = '0; e_data = 8'h00; e_isk = 1'b0; e_abort = 1'b0;
        if (ena) begin
            if (m_sending) begin
                if (src_req[m_owner]) begin
                    b = src_q[m_owner].pop_front();
                    e_data = b.data; e_isk = b.isk; e_ack[m_owner] = 1'b1;
                    m_wdt = 0;
                    if (b.last) begin m_sending = 0; m_gap = 1; end
                end else begin
                    m_wdt++;
`ifdef FB_TX_ARB_WDT_EN
                    if (m_wdt == WDT) begin
                        e_data = 8'h3C; e_isk = 1'b1; e_abort = 1'b1;
                        m_wdt = 0; m_sending = 0; m_gap = 1;
                        while (src_q[m_owner].size() > 0) begin
                            b = src_q[m_owner].pop_front();
                            if (b.last) break;
                        end
                    end else
`endif
                    begin
                        e_data = IDLE; e_isk = 1'b1;
                    end
                end
            end else if (m_gap) begin
                e_data = IDLE; e_isk = 1'b1; m_gap = 0;
            end else begin
                e_data = IDLE; e_isk = 1'b1;
                w = pick(src_req);
                if (w >= 0) begin
                    m_sending = 1; m_owner = w; m_grant = 2'(w); m_wdt = 0;
                    if (w != 0) m_ptr = (w == N - 1) ? 1 : w + 1;
                end
            end
            for (int s = 0; s < N; s++) if (stall_left[s] > 0) stall_left[s]--;
            slot_log.push_back({tx_isk_out, tx_data_out});
        end
        check("src_ack", 32'(src_ack), 32'(e_ack));
        check("tx_data_out", 32'(tx_data_out), 32'(e_data));
        check("tx_isk_out", 32'(tx_isk_out), 32'(e_isk));
        check("abort", 32'(abort), 32'(e_abort));
        for (int s = 0; s < N; s++) if (src_ack[s]) ack_cnt[s]++;
        if (abort) abort_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        tx_ena = 1'b1;
        drive();
        @(negedge clk);
        rst    = 1'b0;
        tx_ena = 1'b0;
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            stall_left[s] = 0;
        end
        drive();
        m_sending = 0; m_gap = 0; m_owner = 0; m_ptr = 1; m_wdt = 0; m_grant = 2'd0;
        prev_busy = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src_ack", 32'(src_ack), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
    endtask

    task automatic cmp_slots(input string name);
        for (int i = 0; i < exp_slots.size(); i++)
            check($sformatf("%s_slot%0d", name, i),
                  (i < slot_log.size()) ? 32'(slot_log[i]) : 32'hFFFF_FFFF, 32'(exp_slots[i]));
    endtask

    task automatic cmp_grants(input string name);
        for (int i = 0; i < exp_grants.size(); i++)
            check($sformatf("%s_grant%0d", name, i),
                  (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_grants[i]));
    endtask

    initial begin
        rst = 1'b1; tx_ena = 1'b0;
        src_req = '0; src_data = '0; src_isk = '0; src_last = '0;

        // basic 3-byte packet from source 1
        do_reset(); clear_logs();
        add_byte(1, 8'h5C, 1'b1, 1'b0);
        add_byte(1, 8'h07, 1'b0, 1'b0);
        add_byte(1, 8'hAA, 1'b0, 1'b1);
        repeat (6) step(1);
        exp_slots = '{9'h1BC, 9'h15C, 9'h007, 9'h0AA, 9'h1BC};
        cmp_slots("basic");
        check("basic_ack1_count", 32'(ack_cnt[1]), 32'd3);

        // round-robin among 1..3, then source 0 priority
        do_reset(); clear_logs();
        for (int s = 1; s < N; s++)
            repeat (2) begin
                add_byte(s, 8'(16 * s), 1'b0, 1'b0);
                add_byte(s, 8'(16 * s + 1), 1'b0, 1'b1);
            end
        repeat (30) step(1);
        add_byte(0, 8'h01, 1'b0, 1'b1);
        add_byte(2, 8'h02, 1'b0, 1'b1);
        repeat (10) step(1);
        exp_grants = '{1, 2, 3, 1, 2, 3, 0, 2};
        cmp_grants("rr");

        // sparse tx_ena
        do_reset(); clear_logs();
        add_byte(3, 8'h11, 1'b0, 1'b0);
        add_byte(3, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(i % 4 == 0);
        exp_slots = '{9'h1BC, 9'h011, 9'h022, 9'h1BC};
        cmp_slots("sparse");
        check("sparse_ack3_count", 32'(ack_cnt[3]), 32'd2);

        // owner stall holds the lane against a waiting source
        do_reset(); clear_logs();
        add_byte(2, 8'h21, 1'b0, 1'b0);
        add_byte(2, 8'h22, 1'b0, 1'b0);
        add_byte(2, 8'h23, 1'b0, 1'b0);
        add_byte(2, 8'h24, 1'b0, 1'b1);
        add_byte(3, 8'h31, 1'b0, 1'b1);
        repeat (2) step(1);
        stall_left[2] = 5;
        repeat (12) step(1);
        exp_slots = '{9'h1BC, 9'h021, 9'h1BC, 9'h1BC, 9'h1BC, 9'h1BC, 9'h1BC,
                      9'h022, 9'h023, 9'h024, 9'h1BC, 9'h1BC, 9'h031};
        cmp_slots("stall");
        exp_grants = '{2, 3};
        cmp_grants("stall");

        // long stall: watchdog abort when compiled in, otherwise resumes
        do_reset(); clear_logs();
        add_byte(1, 8'h41, 1'b0, 1'b0);
        add_byte(1, 8'h42, 1'b0, 1'b0);
        add_byte(1, 8'h43, 1'b0, 1'b1);
        repeat (2) step(1);
`ifdef FB_TX_ARB_WDT_EN
        stall_left[1] = 8;
        repeat (10) step(1);
        exp_slots = '{9'h1BC, 9'h041, 9'h1BC, 9'h1BC, 9'h1BC, 9'h1BC, 9'h1BC,
                      9'h1BC, 9'h1BC, 9'h13C, 9'h1BC, 9'h1BC};
        cmp_slots("wdt");
        check("wdt_abort_count", 32'(abort_cnt), 32'd1);
`else
        stall_left[1] = 20;
        repeat (26) step(1);
        check("nowdt_abort_count", 32'(abort_cnt), 32'd0);
        check("nowdt_ack1_count", 32'(ack_cnt[1]), 32'd3);
`endif

        // reset mid-packet, then a fresh request
        do_reset(); clear_logs();
        add_byte(1, 8'h61, 1'b0, 1'b0);
        add_byte(1, 8'h62, 1'b0, 1'b0);
        add_byte(1, 8'h63, 1'b0, 1'b0);
        add_byte(1, 8'h64, 1'b0, 1'b1);
        repeat (3) step(1);
        do_reset(); clear_logs();
        add_byte(3, 8'h71, 1'b0, 1'b1);
        repeat (2) step(1);
        exp_slots = '{9'h1BC, 9'h071};
        cmp_slots("rst_mid");
        exp_grants = '{3};
        cmp_grants("rst_mid");

        // randomized traffic
        do_reset(); clear_logs();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int s = 0; s < N; s++) begin
                if (src_q[s].size() == 0 && $urandom_range(0, 9) == 0) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++)
                        add_byte(s, 8'($urandom), 1'($urandom_range(0, 7) == 0), 1'(i == len - 1));
                end
                if (src_q[s].size() > 0 && stall_left[s] == 0 && $urandom_range(0, 39) == 0)
                    stall_left[s] = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 799) == 0) do_reset();
            else step($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
